uart_tx_serializer: RTL and testbench

- Transmit half of the UART core. Pops words from the TX FIFO's first-word-fall-through read port and serializes each one onto tx_pin.
- Frame format: start bit, then 5..16 data bits LSB first, then optional parity bit, then 1 or 2 stop bits.
- Bit timing and frame format come from runtime configuration registers, which the parent uart loads via config_address/config_value.
- Drives the line that the uart receiver samples in loopback.

---
 rtl/uart_tx_serializer_pkg.sv | 53 +++++
 rtl/uart_tx_serializer_baud_timer.sv | 28 ++
 rtl/uart_tx_serializer.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: parity/stop encodings, FSM state encoding,
// configuration widths and the data-bit clamp helper.
package uart_tx_serializer_pkg;

  // Width of the clocks-per-bit configuration field and bit timer
  localparam int UART_CONFIG_WIDTH_DELAYFRAMES = 16;

  // Widest data field a frame can carry
  localparam int UART_MAX_DATABITS = 16;
  localparam int UART_MIN_DATABITS = 5;

  // Parity encodings (code 3 is reserved and behaves as no parity)
  localparam logic [1:0] UART_PARITY_NONE = 2'd0;
  localparam logic [1:0] UART_PARITY_ODD  = 2'd1;
  localparam logic [1:0] UART_PARITY_EVEN = 2'd2;
  localparam logic [1:0] UART_PARITY_RSVD = 2'd3;

  // Stop-bit encodings
  localparam logic UART_STOP_ONE = 1'b0;
  localparam logic UART_STOP_TWO = 1'b1;

  // Transmit FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_t;

  // Force a requested data-bit count into the legal 5..16 window
  function automatic logic [4:0] clamp_databits(input logic [4:0] v);
    if (v < 5'(UART_MIN_DATABITS)) begin
      return 5'(UART_MIN_DATABITS);
    end else if (v > 5'(UART_MAX_DATABITS)) begin
      return 5'(UART_MAX_DATABITS);
    end else begin
      return v;
    end
  endfunction

  // Convert clocks-per-bit into the timer reload value; 0 behaves as 1
  function automatic logic [UART_CONFIG_WIDTH_DELAYFRAMES-1:0] delay_reload(
    input logic [UART_CONFIG_WIDTH_DELAYFRAMES-1:0] d
  );
    if (d == '0) begin
      return '0;
    end else begin
      return d - 1'b1;
    end
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_timer.sv
// Loadable bit-time down-counter with a terminal-count strobe.
// Shared between the UART transmitter and receiver.
module uart_baud_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Load takes priority; otherwise count down and rest at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops words from a first-word-fall-through FIFO
// and shifts them out LSB first as start/data/parity/stop frames.
// Optional line-break support is compiled in with UART_TX_BREAK_EN.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DELAY    = 300,
  parameter int DATABITS = 8,
  parameter int DELAY_W  = UART_CONFIG_WIDTH_DELAYFRAMES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATABITS-1:0] tx_data,
  input  logic                tx_empty,
`ifdef UART_TX_BREAK_EN
  input  logic                tx_break,
`endif
  output logic                tx_read,
  output logic                tx_pin,
  output logic                busy,
  input  logic [DELAY_W-1:0]  cfg_delay,
  input  logic [4:0]          cfg_databits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stopbit
);

  localparam int MAXW = UART_MAX_DATABITS;

  tx_state_t         r_state;
  tx_state_t         w_next;

  // Per-frame snapshot of the configuration and payload
  logic [MAXW-1:0]    r_shift;
  logic               r_par_bit;
  logic               r_par_en;
  logic               r_two_stop;
  logic [4:0]         r_nbits;
  logic [DELAY_W-1:0] r_dm1;
  logic [4:0]         r_bitcnt;
  logic               r_en;

  logic               w_tc;
  logic               w_start;
  logic               w_adv;
  logic               w_load;
  logic [DELAY_W-1:0] w_load_val;
  logic [DELAY_W-1:0] w_live_dm1;
  logic [4:0]         w_nbits;
  logic [MAXW-1:0]    w_mask;
  logic [MAXW-1:0]    w_masked;
  logic               w_last_bit;
  logic               w_last_stop;
  logic               w_brk;
  logic               w_brk_load;
  logic               w_hold;

  // Live configuration decoded for the frame about to start
  assign w_nbits    = clamp_databits(cfg_databits);
  assign w_live_dm1 = DELAY_W'(delay_reload(UART_CONFIG_WIDTH_DELAYFRAMES'(cfg_delay)));

  // Keep only the low N bits of the FIFO word
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAXW; i++) begin
      w_mask[i] = (i < int'(w_nbits));
    end
  end

  assign w_masked = MAXW'(tx_data) & w_mask;

  // A frame starts from IDLE only once out of reset, with data and no break hold
  assign w_start = (r_state == ST_IDLE) && !tx_empty && r_en && !w_brk && !w_hold;
  assign tx_read = w_start;

  assign w_last_bit  = (r_bitcnt == (r_nbits - 5'd1));
  assign w_last_stop = !r_two_stop || (r_bitcnt != 5'd0);
  assign w_adv       = (r_state != ST_IDLE) && w_tc;

  // Reload the bit timer at every bit boundary that stays inside a frame
  assign w_load     = w_start || w_brk_load || (w_adv && (w_next != ST_IDLE));
  assign w_load_val = (w_start || w_brk_load) ? w_live_dm1 : r_dm1;

  uart_baud_timer #(
    .W (DELAY_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

`ifdef UART_TX_BREAK_EN
  logic r_hold;

  assign w_brk      = tx_break;
  assign w_brk_load = (r_state == ST_IDLE) && tx_break;
  assign w_hold     = r_hold;

  // After a break, keep the line idle high for one full bit time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 1'b0;
    end else if (w_brk_load) begin
      r_hold <= 1'b1;
    end else if ((r_state == ST_IDLE) && r_hold && w_tc) begin
      r_hold <= 1'b0;
    end
  end
`else
  assign w_brk      = 1'b0;
  assign w_brk_load = 1'b0;
  assign w_hold     = 1'b0;
`endif

  // Gate the first pop until one clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= 1'b0;
    end else begin
      r_en <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_START;
      end
      ST_START: begin
        if (w_tc) w_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_tc && w_last_bit) w_next = r_par_en ? ST_PAR : ST_STOP;
      end
      ST_PAR: begin
        if (w_tc) w_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_tc && w_last_stop) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: line level and busy flag
  always_comb begin
    tx_pin = 1'b1;
    busy   = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        tx_pin = !w_brk;
        busy   = 1'b0;
      end
      ST_START: tx_pin = 1'b0;
      ST_DATA:  tx_pin = r_shift[0];
      ST_PAR:   tx_pin = r_par_bit;
      ST_STOP:  tx_pin = 1'b1;
      default: begin
        tx_pin = 1'b1;
        busy   = 1'b0;
      end
    endcase
  end

  // Frame datapath: snapshot at pop, shift and count at bit boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_two_stop <= 1'b0;
      r_nbits    <= clamp_databits(5'(DATABITS));
      r_dm1      <= DELAY_W'((DELAY > 0) ? DELAY - 1 : 0);
      r_bitcnt   <= '0;
    end else if (w_start) begin
      r_shift    <= w_masked;
      r_par_bit  <= (^w_masked) ^ (cfg_parity == UART_PARITY_ODD);
      r_par_en   <= (cfg_parity == UART_PARITY_ODD) || (cfg_parity == UART_PARITY_EVEN);
      r_two_stop <= (cfg_stopbit == UART_STOP_TWO);
      r_nbits    <= w_nbits;
      r_dm1      <= w_live_dm1;
      r_bitcnt   <= '0;
    end else if (w_adv) begin
      if (r_state == ST_DATA) begin
        r_shift  <= r_shift >> 1;
        r_bitcnt <= w_last_bit ? 5'd0 : r_bitcnt + 5'd1;
      end else if (r_state == ST_STOP) begin
        r_bitcnt <= r_bitcnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a small FWFT FIFO model.
module tb_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tx_data;
  logic        tx_empty;
  logic        tx_break;
  logic        tx_read;
  logic        tx_pin;
  logic        busy;
  logic [15:0] cfg_delay;
  logic [4:0]  cfg_databits;
  logic [1:0]  cfg_parity;
  logic        cfg_stopbit;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mem [0:15];
  logic [3:0] wp = 4'd0;
  logic [3:0] rp = 4'd0;

  logic pin_s  [0:255];
  logic busy_s [0:255];
  logic rd_s   [0:255];
  bit   exp_q  [$];

  always #5 clk = ~clk;

  assign tx_data  = mem[rp];
  assign tx_empty = (wp == rp);

  always @(posedge clk) if (tx_read === 1'b1) rp <= rp + 4'd1;

  uart_tx_serializer #(.DELAY(300), .DATABITS(8), .DELAY_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_empty     (tx_empty),
`ifdef UART_TX_BREAK_EN
    .tx_break     (tx_break),
`endif
    .tx_read      (tx_read),
    .tx_pin       (tx_pin),
    .busy         (busy),
    .cfg_delay    (cfg_delay),
    .cfg_databits (cfg_databits),
    .cfg_parity   (cfg_parity),
    .cfg_stopbit  (cfg_stopbit)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] v);
    mem[wp] = v;
    wp = wp + 4'd1;
  endtask

  // Wait (bounded) for the pop strobe, then record L further cycles
  task automatic capture(input int L);
    int t;
    t = 0;
    #1;
    while (tx_read !== 1'b1 && t < 64) begin
      @(negedge clk); #1; t++;
    end
    chk("pop_seen", tx_read, 1'b1);
    pin_s[0] = tx_pin; busy_s[0] = busy; rd_s[0] = tx_read;
    for (int c = 1; c <= L; c++) begin
      @(negedge clk); #1;
      pin_s[c] = tx_pin; busy_s[c] = busy; rd_s[c] = tx_read;
    end
  endtask

  // Reference line waveform for one frame followed by one idle clock
  task automatic model_frame(input logic [15:0] d, input int n, input int par,
                             input bit two, input int dd);
    int D;
    bit p;
    D = (dd == 0) ? 1 : dd;
    p = 1'b0;
    for (int k = 0; k < D; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      p = p ^ d[i];
      for (int k = 0; k < D; k++) exp_q.push_back(d[i]);
    end
    if (par == 1 || par == 2) begin
      if (par == 1) p = ~p;
      for (int k = 0; k < D; k++) exp_q.push_back(p);
    end
    for (int k = 0; k < (two ? 2 * D : D); k++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
  endtask

  function automatic int mism();
    int m;
    m = 0;
    for (int i = 0; i < exp_q.size(); i++) if (pin_s[i+1] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic int cnt_busy(input int a, input int b);
    int s;
    s = 0;
    for (int i = a; i <= b; i++) if (busy_s[i] === 1'b1) s++;
    return s;
  endfunction

  function automatic int cnt_rd(input int a, input int b);
    int s;
    s = 0;
    for (int i = a; i <= b; i++) if (rd_s[i] === 1'b1) s++;
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] obs10;
    int cnt;
    rst_n = 1'b0; tx_break = 1'b0;
    cfg_delay = 16'd4; cfg_databits = 5'd8; cfg_parity = 2'd0; cfg_stopbit = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pin", tx_pin, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_read", tx_read, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // D=4, 8N1, 0xA5
    push(8'hA5);
    capture(41);
    for (int b = 0; b < 10; b++) obs10[b] = pin_s[1 + 4*b + 1];
    chk("a5_bits", obs10, 10'h34A);
    chk("a5_busy", cnt_busy(0, 41), 40);
    chk("a5_reads", cnt_rd(0, 41), 1);
    chk("a5_idle", {pin_s[41], busy_s[41]}, 2'b10);
    exp_q.delete(); model_frame(16'hA5, 8, 0, 0, 4);
    chk("a5_wave", mism(), 0);
    @(negedge clk);

    // Odd parity, 0x03
    cfg_parity = 2'd1;
    push(8'h03);
    capture(45);
    chk("odd_par", pin_s[38], 1'b1);
    chk("odd_busy", cnt_busy(0, 45), 44);
    @(negedge clk);

    // Even parity, 0x03
    cfg_parity = 2'd2;
    push(8'h03);
    capture(45);
    chk("even_par", pin_s[38], 1'b0);
    chk("even_busy", cnt_busy(0, 45), 44);
    exp_q.delete(); model_frame(16'h03, 8, 2, 0, 4);
    chk("even_wave", mism(), 0);
    @(negedge clk);

    // Two stop bits, N=5, back-to-back 0x1F, 0x00
    cfg_parity = 2'd0; cfg_databits = 5'd5; cfg_stopbit = 1'b1;
    push(8'h1F); push(8'h00);
    capture(66);
    cnt = 0;
    for (int i = 25; i <= 32; i++) if (pin_s[i] === 1'b1) cnt++;
    chk("stop2_high", cnt, 8);
    chk("gap_idle", {pin_s[33], busy_s[33]}, 2'b10);
    chk("gap_start", {pin_s[34], busy_s[34]}, 2'b01);
    chk("b2b_reads", cnt_rd(0, 66), 2);
    chk("b2b_busy", cnt_busy(0, 66), 64);
    exp_q.delete(); model_frame(16'h1F, 5, 0, 1, 4); model_frame(16'h00, 5, 0, 1, 4);
    chk("b2b_wave", mism(), 0);
    @(negedge clk);

    // cfg_delay=0, databits 8 -> 7 mid-frame
    cfg_delay = 16'd0; cfg_databits = 5'd8; cfg_stopbit = 1'b0;
    push(8'h81); push(8'h80);
    fork
      capture(22);
      begin repeat (3) @(negedge clk); cfg_databits = 5'd7; end
    join
    chk("d0_busy", cnt_busy(0, 22), 19);
    chk("d0_b_last", {busy_s[20], busy_s[21]}, 2'b10);
    exp_q.delete(); model_frame(16'h81, 8, 0, 0, 0); model_frame(16'h80, 7, 0, 0, 0);
    chk("d0_wave", mism(), 0);
    @(negedge clk);

    // Reset during DATA, FIFO still holding a word
    cfg_delay = 16'd4; cfg_databits = 5'd8;
    push(8'hC3); push(8'h3C);
    capture(12);
    chk("pre_rst_pin", pin_s[12], 1'b1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mid_rst_pin", tx_pin, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_read", tx_read, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    capture(41);
    exp_q.delete(); model_frame(16'h3C, 8, 0, 0, 4);
    chk("post_rst_wave", mism(), 0);
    chk("post_rst_reads", cnt_rd(0, 41), 1);
    @(negedge clk);

`ifdef UART_TX_BREAK_EN
    // Break for 20 clocks in IDLE with a word waiting
    tx_break = 1'b1;
    push(8'h55);
    cnt = 0;
    #1; if (tx_pin === 1'b0) cnt++;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk); #1;
      if (tx_pin === 1'b0) cnt++;
    end
    chk("brk_low", cnt, 20);
    @(negedge clk); tx_break = 1'b0; #1;
    cnt = 0;
    for (int i = 0; i < 50 && tx_pin === 1'b1; i++) begin
      cnt++;
      @(negedge clk); #1;
    end
    chk("brk_hold", (cnt >= 4 && cnt < 50), 1'b1);
    repeat (50) @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
